// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, datapath select encodings, control state enum and control vector
package mips_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG_A  = 2'b11;
  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP
  } state_t;
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
  } ctrl_t;
  function automatic logic legal_op(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI};
  endfunction
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: controller <-> datapath/memory control bundle
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       jr;
  logic       zero;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal_op;
  modport master (
    input  opcode, jr, zero, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal_op
  );
  modport slave (
    output opcode, jr, zero, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal_op
  );
endinterface

// File: rtl/multicycle_control_ctrl_decode.sv
// ctrl_decode: combinational state -> datapath control vector
module ctrl_decode import mips_pkg::*; (
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       jr,
  input  logic       zero,
  output ctrl_t      ctrl
);
  // every field defaults to 0; each state raises only what it needs
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRC_B_IMM_SH;
        ctrl.illegal_op = !legal_op(opcode);
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
        ctrl.pc_en     = jr;
        ctrl.pc_source = jr ? PC_REG_A : PC_ALU;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = opcode == OP_ORI ? ALU_OR : ALU_ADD;
      end
      S_I_WB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PC_BRANCH;
        ctrl.pc_en     = zero;
      end
      S_JUMP: begin
        ctrl.pc_source = PC_JUMP;
        ctrl.pc_en     = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM with memory stall handshake and retire counter
module multicycle_control import mips_pkg::*; #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_control_if.master bus,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);
  state_t cur, nxt;
  ctrl_t  ctrl;
  logic   retire;
  ctrl_decode u_decode (
    .state    (cur),
    .opcode   (bus.opcode),
    .mem_ready(bus.mem_ready),
    .jr       (bus.jr),
    .zero     (bus.zero),
    .ctrl     (ctrl)
  );
  assign bus.mem_read   = ctrl.mem_read;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.i_or_d     = ctrl.i_or_d;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.pc_en      = ctrl.pc_en;
  assign bus.pc_source  = ctrl.pc_source;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.illegal_op = ctrl.illegal_op;
  assign state          = cur;
  // next state: memory states hold until mem_ready, decode dispatches on opcode
  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:    nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   nxt = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? S_MEM_ADDR :
                        bus.opcode == OP_R ? S_R_EXEC :
                        (bus.opcode == OP_ADDI || bus.opcode == OP_ORI) ? S_I_EXEC :
                        bus.opcode == OP_BEQ ? S_BRANCH :
                        bus.opcode == OP_J ? S_JUMP : S_FETCH;
      S_MEM_ADDR: nxt = bus.opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   nxt = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   nxt = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   nxt = bus.jr ? S_FETCH : S_R_WB;
      S_I_EXEC:   nxt = S_I_WB;
      default:    nxt = S_FETCH;
    endcase
  end
  // decode only returns to fetch on an illegal opcode, which is not a retirement
  assign retire = nxt == S_FETCH && cur != S_FETCH && cur != S_DECODE;
  // state register and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur     <= S_FETCH;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (retire) retired <= retired + CNT_W'(1);
    end
endmodule
